// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - datapath/display-side signal bundle for seg_scan_driver
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    pending;
  logic                    frame_tick;
  logic [6:0]              segments;
  logic [NUM_DIGITS-1:0]   digit_en;

  modport master (
    output value, load, blank_mask,
    input  pending, frame_tick, segments, digit_en
  );

  modport slave (
    input  value, load, blank_mask,
    output pending, frame_tick, segments, digit_en
  );
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scanner with dead-time guard and frame-aligned updates
// Optional: define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always shown).
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 8,
  parameter int SEG_ACT_LOW  = 0,
  parameter int DIG_ACT_LOW  = 0
) (
  input logic              clk,
  input logic              reset_n,
  seg_scan_driver_if.slave bus
);

  localparam int CNT_MAX = (SCAN_CYCLES > GUARD_CYCLES) ? SCAN_CYCLES : GUARD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Inactive levels double as XOR masks that apply the output polarity.
  localparam logic [6:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                 : {NUM_DIGITS{1'b0}};

  typedef enum logic {st_show, st_guard} state_t;

  state_t                  state, state_d;
  logic [IW-1:0]           idx, idx_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic                    commit;
  logic [4*NUM_DIGITS-1:0] staged, shown;
  logic                    pending_q, tick_q;
  logic [6:0]              seg_q, seg_d, seg_lit;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              nib;
  logic                    blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h7E;
      4'h1: hex_to_seg = 7'h30;
      4'h2: hex_to_seg = 7'h6D;
      4'h3: hex_to_seg = 7'h79;
      4'h4: hex_to_seg = 7'h33;
      4'h5: hex_to_seg = 7'h5B;
      4'h6: hex_to_seg = 7'h5F;
      4'h7: hex_to_seg = 7'h70;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h7B;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h1F;
      4'hC: hex_to_seg = 7'h4E;
      4'hD: hex_to_seg = 7'h3D;
      4'hE: hex_to_seg = 7'h4F;
      default: hex_to_seg = 7'h47;
    endcase
  endfunction

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt + 1'b1;
    commit  = 1'b0;
    case (state)
      st_show: begin
        if (cnt == SCAN_LAST) begin
          cnt_d   = '0;
          idx_d   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          // Wrapping past the last digit is the only point a staged value may be shown.
          commit  = (idx == IDX_LAST) && pending_q;
          state_d = (GUARD_CYCLES == 0) ? st_show : st_guard;
        end
      end
      st_guard: begin
        if (cnt == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = st_show;
        end
      end
      default: begin
        state_d = st_show;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic upper_zero;
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero  = upper_zero & (shown[4*i +: 4] == 4'h0);
      lz_blank[i] = upper_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    nib     = shown[{idx, 2'b00} +: 4];
    blank   = bus.blank_mask[idx] | lz_blank[idx];
    seg_lit = blank ? 7'h00 : hex_to_seg(nib);
    seg_d   = SEG_OFF;
    dig_d   = DIG_OFF;
    if (state == st_show) begin
      seg_d = seg_lit ^ SEG_OFF;
      dig_d = (NUM_DIGITS'(1) << idx) ^ DIG_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= st_show;
      idx       <= '0;
      cnt       <= '0;
      staged    <= '0;
      shown     <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      seg_q     <= SEG_OFF;
      dig_q     <= DIG_OFF;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      cnt       <= cnt_d;
      if (bus.load) staged <= bus.value;
      if (commit)   shown  <= staged;
      // A load landing on the commit edge re-arms pending for the following frame.
      pending_q <= bus.load | (pending_q & ~commit);
      tick_q    <= commit;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
    end
  end

  assign bus.pending    = pending_q;
  assign bus.frame_tick = tick_q;
  assign bus.segments   = seg_q;
  assign bus.digit_en   = dig_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - table-driven bench for seg_scan_driver (4 digits, scan 4, guard 2)
module tb_seg_scan_driver;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  // Segment pattern for a zero digit that sits above all-zero nibbles.
  localparam logic [6:0] ZU = LZB ? 7'h00 : 7'h7E;

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic [3:0]  mask;
    logic [3:0]  de;
    logic [6:0]  seg;
    logic        pend;
    logic        tick;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_miss;
  vec_t vecs[$];

  seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS  (4),
    .SCAN_CYCLES (4),
    .GUARD_CYCLES(2),
    .SEG_ACT_LOW (0),
    .DIG_ACT_LOW (0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_outs(input string tag, input logic [3:0] de, input logic [6:0] seg,
                            input logic pend, input logic tick);
    n_vec++;
    if (bus.digit_en !== de) begin
      n_miss++;
      $display("FAIL %s digit_en got %b expected %b", tag, bus.digit_en, de);
    end
    if (bus.segments !== seg) begin
      n_miss++;
      $display("FAIL %s segments got %h expected %h", tag, bus.segments, seg);
    end
    if (bus.pending !== pend) begin
      n_miss++;
      $display("FAIL %s pending got %b expected %b", tag, bus.pending, pend);
    end
    if (bus.frame_tick !== tick) begin
      n_miss++;
      $display("FAIL %s frame_tick got %b expected %b", tag, bus.frame_tick, tick);
    end
  endtask

  // One 24-cycle frame: 4 lit cycles then 2 dark cycles per digit.
  task automatic add_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input logic [3:0] mask, input logic pend);
    logic [6:0] s[4];
    vec_t       v;
    int         d;
    s = '{s0, s1, s2, s3};
    for (int p = 0; p < 24; p++) begin
      d      = p / 6;
      v.ld   = 1'b0;
      v.val  = 16'h0000;
      v.mask = mask;
      v.pend = pend;
      v.tick = 1'b0;
      if ((p % 6) < 4) begin
        v.de  = 4'b0001 << d;
        v.seg = mask[d] ? 7'h00 : s[d];
      end else begin
        v.de  = 4'b0000;
        v.seg = 7'h00;
      end
      vecs.push_back(v);
    end
  endtask

  task automatic set_load(input int idx, input logic [15:0] val);
    vecs[idx].ld  = 1'b1;
    vecs[idx].val = val;
  endtask

  task automatic set_pend(input int first, input int last, input logic pend);
    for (int i = first; i <= last; i++) vecs[i].pend = pend;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    bus.value      = '0;
    bus.load       = 1'b0;
    bus.blank_mask = '0;

    // A: idle frame after reset
    add_frame(7'h7E, ZU, ZU, ZU, 4'b0000, 1'b0);
    // B: load 12AF mid-frame, committed at the wrap
    add_frame(7'h7E, ZU, ZU, ZU, 4'b0000, 1'b0);
    set_load(24 + 5, 16'h12AF);
    set_pend(24 + 5, 24 + 20, 1'b1);
    vecs[24 + 21].tick = 1'b1;
    // C: shows 12AF; two loads, last one wins
    add_frame(7'h47, 7'h77, 7'h6D, 7'h30, 4'b0000, 1'b0);
    set_load(48 + 2, 16'h1111);
    set_load(48 + 10, 16'h2222);
    set_pend(48 + 2, 48 + 20, 1'b1);
    vecs[48 + 21].tick = 1'b1;
    // D: shows 2222 with digit 2 masked; load on the commit cycle
    add_frame(7'h6D, 7'h6D, 7'h6D, 7'h6D, 4'b0100, 1'b0);
    set_load(72 + 5, 16'h4444);
    set_load(72 + 21, 16'h5555);
    set_pend(72 + 5, 72 + 23, 1'b1);
    vecs[72 + 21].tick = 1'b1;
    // E: shows the older staged value 4444 while 5555 waits
    add_frame(7'h33, 7'h33, 7'h33, 7'h33, 4'b0000, 1'b1);
    vecs[96 + 21].tick = 1'b1;
    set_pend(96 + 21, 96 + 23, 1'b0);
    // F: shows 5555; stage 0050 for the final frame
    add_frame(7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'b0000, 1'b0);
    set_load(120 + 3, 16'h0050);
    set_pend(120 + 3, 120 + 20, 1'b1);
    vecs[120 + 21].tick = 1'b1;

    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 4'b0000, 7'h00, 1'b0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.load       = vecs[i].ld;
      bus.value      = vecs[i].val;
      bus.blank_mask = vecs[i].mask;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].de, vecs[i].seg, vecs[i].pend, vecs[i].tick);
    end

    // G: 0050 frame, load during digit 2, then asynchronous reset mid-window
    bus.blank_mask = 4'b0000;
    for (int p = 0; p <= 12; p++) begin
      bus.load  = (p == 12);
      bus.value = 16'h9999;
      @(posedge clk);
      #1;
      if (p == 0)  check_outs("g_digit0", 4'b0001, 7'h7E, 1'b0, 1'b0);
      if (p == 6)  check_outs("g_digit1", 4'b0010, 7'h5B, 1'b0, 1'b0);
      if (p == 12) check_outs("g_digit2", 4'b0100, ZU, 1'b1, 1'b0);
    end
    bus.load = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_outs("async_rst", 4'b0000, 7'h00, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_outs("rst_hold", 4'b0000, 7'h00, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Restart from digit 0; the staged 9999 was lost, shown is zero again
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) check_outs("restart_d0", 4'b0001, 7'h7E, 1'b0, 1'b0);
      if (k == 4) check_outs("restart_gd", 4'b0000, 7'h00, 1'b0, 1'b0);
      if (k == 6) check_outs("restart_d1", 4'b0010, ZU, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
